// File: rtl/i2c_gpio_pkg.sv
// Shared definitions for the I2C GPIO expander target.
// Holds the bus FSM state encoding, the register map indices and the register
// reset constants used by i2c_gpio_target and its helpers.
`timescale 1ns/1ps

package i2c_gpio_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic [2:0] REG_IN0  = 3'd0;
    localparam logic [2:0] REG_IN1  = 3'd1;
    localparam logic [2:0] REG_OUT0 = 3'd2;
    localparam logic [2:0] REG_OUT1 = 3'd3;
    localparam logic [2:0] REG_POL0 = 3'd4;
    localparam logic [2:0] REG_POL1 = 3'd5;
    localparam logic [2:0] REG_CFG0 = 3'd6;
    localparam logic [2:0] REG_CFG1 = 3'd7;

    localparam logic [7:0] OUT_RST = 8'hFF;
    localparam logic [7:0] POL_RST = 8'h00;
    localparam logic [7:0] CFG_RST = 8'hFF;

    // Highest pointer value the target accepts.
    localparam logic [7:0] PTR_MAX = 8'h07;

endpackage

// File: rtl/i2c_gpio_target_bus_sync.sv
// i2c_bus_sync: brings the asynchronous SCL/SDA lines into the system clock
// domain and derives bus events from them.
// Ports:
//   s_clk_25mhz, rst_n   system clock, async active-low reset
//   scl_in, sda_in       raw bus lines
//   scl_rise, scl_fall   one-clock pulses on synchronised SCL edges
//   start_det, stop_det  one-clock pulses for START / STOP conditions
//   sda_s                synchronised SDA level
`timescale 1ns/1ps

module i2c_bus_sync
    import i2c_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic s_clk_25mhz,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Synchroniser chains plus one history flop per line. Everything resets
    // to 1 so an idle bus produces no spurious edges when reset is released.
    always_ff @(posedge s_clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // SDA moving while SCL is held high (now and one clock ago) is a
    // START or STOP; SDA never changes around an SCL edge for normal data.
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_gpio_target.sv
// i2c_gpio_target: I2C target modelling a 16-bit GPIO expander.
// Registers: 0/1 input (gpio_in XOR polarity), 2/3 output, 4/5 polarity,
// 6/7 config (bit = 1 means input, so gpio_oe is the inverse).
// Ports:
//   s_clk_25mhz, rst_n   system clock, async active-low reset
//   scl_in, sda_in       raw bus lines
//   sda_oe               1 = pull SDA low
//   gpio_in              pin levels read through registers 0/1
//   gpio_out, gpio_oe    {reg3,reg2} and ~{reg7,reg6}
//   wr_strobe, wr_reg    one-clock commit pulse and committed register index
`timescale 1ns/1ps

module i2c_gpio_target
    import i2c_gpio_pkg::*;
#(
    parameter logic [6:0] ADDR7       = 7'h74,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        s_clk_25mhz,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic [15:0] gpio_oe,
    output logic        wr_strobe,
    output logic [2:0]  wr_reg
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic       rw, rw_nxt;
    logic       mack, mack_nxt;
    logic       sda_oe_nxt;
    logic       wr_strobe_nxt;
    logic [2:0] wr_reg_nxt;
    logic [7:0] out0, out0_nxt;
    logic [7:0] out1, out1_nxt;
    logic [7:0] pol0, pol0_nxt;
    logic [7:0] pol1, pol1_nxt;
    logic [7:0] cfg0, cfg0_nxt;
    logic [7:0] cfg1, cfg1_nxt;
    logic [2:0] load_ptr;
    logic [7:0] rd_byte;
    logic [7:0] wr_byte;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .s_clk_25mhz (s_clk_25mhz),
        .rst_n       (rst_n),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .sda_s       (sda_s)
    );

    // Byte presented on a read load. After a master ACK the pointer toggles
    // in the same clock as the load, so the mux looks ahead to the new value.
    always_comb begin
        load_ptr = (state == ST_RDATA_ACK) ? {ptr[2:1], ~ptr[0]} : ptr;
        rd_byte  = 8'h00;
        case (load_ptr)
            REG_IN0:  rd_byte = gpio_in[7:0] ^ pol0;
            REG_IN1:  rd_byte = gpio_in[15:8] ^ pol1;
            REG_OUT0: rd_byte = out0;
            REG_OUT1: rd_byte = out1;
            REG_POL0: rd_byte = pol0;
            REG_POL1: rd_byte = pol1;
            REG_CFG0: rd_byte = cfg0;
            REG_CFG1: rd_byte = cfg1;
            default:  rd_byte = 8'h00;
        endcase
    end

    assign wr_byte = {shift[6:0], sda_s};

    // Next-state and datapath decode. START/STOP override everything; data
    // bits are counted on SCL rise and SDA is only changed on SCL fall. A
    // received byte is complete when bit_cnt reaches 8 and is acted on at
    // the following SCL fall, except write data which commits on bit 8 so a
    // STOP inside the byte can never produce a partial update.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        ptr_nxt       = ptr;
        rw_nxt        = rw;
        mack_nxt      = mack;
        sda_oe_nxt    = sda_oe;
        wr_strobe_nxt = 1'b0;
        wr_reg_nxt    = wr_reg;
        out0_nxt      = out0;
        out1_nxt      = out1;
        pol0_nxt      = pol0;
        pol1_nxt      = pol1;
        cfg0_nxt      = cfg0;
        cfg1_nxt      = cfg1;

        if (start_det) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_nxt   = wr_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (state == ST_WDATA && bit_cnt == 4'd7) begin
                            case (ptr)
                                REG_OUT0: out0_nxt = wr_byte;
                                REG_OUT1: out1_nxt = wr_byte;
                                REG_POL0: pol0_nxt = wr_byte;
                                REG_POL1: pol1_nxt = wr_byte;
                                REG_CFG0: cfg0_nxt = wr_byte;
                                REG_CFG1: cfg1_nxt = wr_byte;
                                default: ;
                            endcase
                            if (ptr != REG_IN0 && ptr != REG_IN1) begin
                                wr_strobe_nxt = 1'b1;
                                wr_reg_nxt    = ptr;
                            end
                            ptr_nxt = {ptr[2:1], ~ptr[0]};
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = 4'd0;
                        if (state == ST_ADDR) begin
                            if (shift[7:1] == ADDR7) begin
                                state_nxt  = ST_ADDR_ACK;
                                rw_nxt     = shift[0];
                                sda_oe_nxt = 1'b1;
                            end else begin
                                state_nxt  = ST_IGNORE;
                            end
                        end else if (state == ST_PTR) begin
                            if (shift <= PTR_MAX) begin
                                state_nxt  = ST_PTR_ACK;
                                ptr_nxt    = shift[2:0];
                                sda_oe_nxt = 1'b1;
                            end else begin
                                state_nxt  = ST_IGNORE;
                            end
                        end else begin
                            state_nxt  = ST_WDATA_ACK;
                            sda_oe_nxt = 1'b1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = 4'd0;
                        if (rw) begin
                            state_nxt  = ST_RDATA;
                            shift_nxt  = rd_byte;
                            sda_oe_nxt = ~rd_byte[7];
                        end else begin
                            state_nxt  = ST_PTR;
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_nxt   = ST_WDATA;
                        bit_cnt_nxt = 4'd0;
                        sda_oe_nxt  = 1'b0;
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt   = ST_RDATA_ACK;
                            bit_cnt_nxt = 4'd0;
                            sda_oe_nxt  = 1'b0;
                        end else begin
                            shift_nxt  = {shift[6:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_nxt = ~sda_s;
                    end else if (scl_fall) begin
                        if (mack) begin
                            state_nxt   = ST_RDATA;
                            ptr_nxt     = load_ptr;
                            shift_nxt   = rd_byte;
                            bit_cnt_nxt = 4'd0;
                            sda_oe_nxt  = ~rd_byte[7];
                        end else begin
                            state_nxt  = ST_IGNORE;
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    // State and register storage; reset releases SDA and restores the
    // power-on register image immediately.
    always_ff @(posedge s_clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            ptr       <= 3'd0;
            rw        <= 1'b0;
            mack      <= 1'b0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_reg    <= 3'd0;
            out0      <= OUT_RST;
            out1      <= OUT_RST;
            pol0      <= POL_RST;
            pol1      <= POL_RST;
            cfg0      <= CFG_RST;
            cfg1      <= CFG_RST;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            ptr       <= ptr_nxt;
            rw        <= rw_nxt;
            mack      <= mack_nxt;
            sda_oe    <= sda_oe_nxt;
            wr_strobe <= wr_strobe_nxt;
            wr_reg    <= wr_reg_nxt;
            out0      <= out0_nxt;
            out1      <= out1_nxt;
            pol0      <= pol0_nxt;
            pol1      <= pol1_nxt;
            cfg0      <= cfg0_nxt;
            cfg1      <= cfg1_nxt;
        end
    end

    assign gpio_out = {out1, out0};
    assign gpio_oe  = ~{cfg1, cfg0};

endmodule

// File: tb/tb_i2c_gpio_target.sv
// Testbench for i2c_gpio_target: drives the bus as an I2C master through an
// open-drain model and checks the target against a register-map model.
`timescale 1ns/1ps

module tb_i2c_gpio_target;

    logic        s_clk_25mhz = 1'b0;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        wr_strobe;
    logic [2:0]  wr_reg;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_reg [8];
    logic [7:0] wbuf  [4];
    logic [7:0] rbuf  [4];
    logic [2:0] got_q [$];
    logic [2:0] exp_q [$];

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_gpio_target #(
        .ADDR7       (7'h74),
        .SYNC_STAGES (2)
    ) dut (
        .s_clk_25mhz (s_clk_25mhz),
        .rst_n       (rst_n),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .wr_strobe   (wr_strobe),
        .wr_reg      (wr_reg)
    );

    // 25 MHz system clock.
    always #20 s_clk_25mhz = ~s_clk_25mhz;

    // Record every commit pulse seen by the target.
    always @(negedge s_clk_25mhz) begin
        if (rst_n && wr_strobe) got_q.push_back(wr_reg);
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #2_400_000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic scl, input logic sda, input int clocks);
        @(negedge s_clk_25mhz);
        scl_m = scl;
        sda_m = sda;
        repeat (clocks - 1) @(negedge s_clk_25mhz);
    endtask

    task automatic modelReset();
        m_reg[0] = 8'h00; m_reg[1] = 8'h00;
        m_reg[2] = 8'hFF; m_reg[3] = 8'hFF;
        m_reg[4] = 8'h00; m_reg[5] = 8'h00;
        m_reg[6] = 8'hFF; m_reg[7] = 8'hFF;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_gpio_out"}, {16'h0, gpio_out}, {16'h0, m_reg[3], m_reg[2]});
        checkOutput({tag, "_gpio_oe"}, {16'h0, gpio_oe}, {16'h0, ~m_reg[7], ~m_reg[6]});
    endtask

    task automatic checkStrobes(input string tag);
        checkOutput({tag, "_strobe_cnt"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s_strobe%0d", tag, i), {29'h0, got_q[i]}, {29'h0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    // Each bit starts by lowering SCL and ends with SCL still high.
    task automatic sendBit(input logic b);
        applyStimulus(1'b0, sda_m, 5);
        applyStimulus(1'b0, b, 5);
        applyStimulus(1'b1, b, 10);
    endtask

    task automatic recvBit(output logic b);
        applyStimulus(1'b0, sda_m, 5);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 5);
        b = sda_in;
        applyStimulus(1'b1, 1'b1, 5);
    endtask

    task automatic i2cStart();
        applyStimulus(1'b0, sda_m, 5);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
    endtask

    task automatic i2cStop();
        applyStimulus(1'b0, sda_m, 5);
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) sendBit(d[i]);
        recvBit(b);
        ack = ~b;
    endtask

    task automatic readByte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recvBit(b);
            d[i] = b;
        end
        sendBit(~ack);
    endtask

    // Full write transaction: address, pointer, n bytes from wbuf, STOP.
    // Model: pointers 2..7 store and strobe, 0/1 discard; pointer[0] toggles.
    task automatic i2cWriteRegs(input logic [2:0] ptr, input int n, input string tag);
        logic       ack;
        logic [2:0] p;
        p = ptr;
        i2cStart();
        writeByte(8'hE8, ack);
        checkOutput({tag, "_addr_ack"}, {31'h0, ack}, 32'd1);
        writeByte({5'd0, ptr}, ack);
        checkOutput({tag, "_ptr_ack"}, {31'h0, ack}, 32'd1);
        for (int k = 0; k < n; k++) begin
            writeByte(wbuf[k], ack);
            checkOutput($sformatf("%s_data%0d_ack", tag, k), {31'h0, ack}, 32'd1);
            if (p >= 3'd2) begin
                m_reg[p] = wbuf[k];
                exp_q.push_back(p);
            end
            p = p ^ 3'd1;
        end
        i2cStop();
    endtask

    // Pointer write, repeated START, then n reads (ACK all but the last).
    // Model: registers 0/1 return pins XOR polarity, others their contents.
    task automatic i2cReadRegs(input logic [2:0] ptr, input int n, input string tag);
        logic       ack;
        logic [2:0] p;
        logic [7:0] exp;
        p = ptr;
        i2cStart();
        writeByte(8'hE8, ack);
        checkOutput({tag, "_addr_ack"}, {31'h0, ack}, 32'd1);
        writeByte({5'd0, ptr}, ack);
        checkOutput({tag, "_ptr_ack"}, {31'h0, ack}, 32'd1);
        i2cStart();
        writeByte(8'hE9, ack);
        checkOutput({tag, "_raddr_ack"}, {31'h0, ack}, 32'd1);
        for (int k = 0; k < n; k++) begin
            if (p == 3'd0)      exp = gpio_in[7:0] ^ m_reg[4];
            else if (p == 3'd1) exp = gpio_in[15:8] ^ m_reg[5];
            else                exp = m_reg[p];
            readByte(rbuf[k], k < n - 1);
            checkOutput($sformatf("%s_rd%0d", tag, k), {24'h0, rbuf[k]}, {24'h0, exp});
            p = p ^ 3'd1;
        end
    endtask

    initial begin
        logic       ack;
        logic [2:0] rptr;
        int         n;

        rst_n   = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        gpio_in = 16'h0000;
        modelReset();
        repeat (5) @(negedge s_clk_25mhz);
        checkOutput("rst_sda_oe", {31'h0, sda_oe}, 32'd0);
        checkOutput("rst_wr_strobe", {31'h0, wr_strobe}, 32'd0);
        checkOutput("rst_wr_reg", {29'h0, wr_reg}, 32'd0);
        checkOutput("rst_gpio_out", {16'h0, gpio_out}, 32'h0000FFFF);
        checkOutput("rst_gpio_oe", {16'h0, gpio_oe}, 32'h00000000);
        rst_n = 1'b1;
        repeat (10) @(negedge s_clk_25mhz);

        $display("[TB] config registers to all-output");
        wbuf[0] = 8'h00;
        i2cWriteRegs(3'd6, 1, "cfg6");
        wbuf[0] = 8'h00;
        i2cWriteRegs(3'd7, 1, "cfg7");
        checkStrobes("cfg");
        checkOutput("cfg_gpio_oe", {16'h0, gpio_oe}, 32'h0000FFFF);

        $display("[TB] output pair write with wrap");
        wbuf[0] = 8'h5A;
        wbuf[1] = 8'hA5;
        i2cWriteRegs(3'd2, 2, "out");
        checkStrobes("out");
        checkOutput("out_gpio_out", {16'h0, gpio_out}, 32'h0000A55A);

        $display("[TB] polarity read-back through repeated START");
        gpio_in = 16'h1234;
        wbuf[0] = 8'hFF;
        i2cWriteRegs(3'd4, 1, "pol");
        checkStrobes("pol");
        i2cReadRegs(3'd0, 2, "rdin");
        checkOutput("rdin_byte0", {24'h0, rbuf[0]}, 32'h000000CB);
        checkOutput("rdin_byte1", {24'h0, rbuf[1]}, 32'h00000012);
        readByte(rbuf[2], 1'b0);
        checkOutput("rdin_released", {24'h0, rbuf[2]}, 32'h000000FF);
        i2cStop();
        checkOutput("rdin_sda_oe", {31'h0, sda_oe}, 32'd0);

        $display("[TB] foreign address");
        i2cStart();
        writeByte(8'hE0, ack);
        checkOutput("addr_e0_ack", {31'h0, ack}, 32'd0);
        writeByte(8'h02, ack);
        checkOutput("addr_e0_data_ack", {31'h0, ack}, 32'd0);
        i2cStop();
        checkModel("addr_e0");
        checkStrobes("addr_e0");
        wbuf[0] = 8'h3C;
        i2cWriteRegs(3'd2, 1, "after_e0");
        checkStrobes("after_e0");
        checkModel("after_e0");

        $display("[TB] bad pointer and STOP inside data byte");
        i2cStart();
        writeByte(8'hE8, ack);
        checkOutput("ptr09_addr_ack", {31'h0, ack}, 32'd1);
        writeByte(8'h09, ack);
        checkOutput("ptr09_ack", {31'h0, ack}, 32'd0);
        writeByte(8'h77, ack);
        checkOutput("ptr09_data_ack", {31'h0, ack}, 32'd0);
        i2cStop();
        checkModel("ptr09");
        i2cStart();
        writeByte(8'hE8, ack);
        writeByte(8'h02, ack);
        checkOutput("midstop_ptr_ack", {31'h0, ack}, 32'd1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        i2cStop();
        checkOutput("midstop_sda_oe", {31'h0, sda_oe}, 32'd0);
        checkModel("midstop");
        checkStrobes("midstop");

        $display("[TB] randomized writes and reads");
        for (int it = 0; it < 8; it++) begin
            rptr = 3'($urandom_range(0, 7));
            n    = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            i2cWriteRegs(rptr, n, $sformatf("rw%0d", it));
            checkStrobes($sformatf("rw%0d", it));
            checkModel($sformatf("rw%0d", it));
            gpio_in = 16'($urandom);
            rptr    = 3'($urandom_range(0, 7));
            i2cReadRegs(rptr, 2, $sformatf("rr%0d", it));
            i2cStop();
        end

        $display("[TB] reset while target holds ACK");
        i2cStart();
        for (int i = 7; i >= 0; i--) sendBit(i == 7 || i == 6 || i == 5 || i == 3);
        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("ackrst_sda_oe_before", {31'h0, sda_oe}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ackrst_sda_oe", {31'h0, sda_oe}, 32'd0);
        checkOutput("ackrst_gpio_out", {16'h0, gpio_out}, 32'h0000FFFF);
        checkOutput("ackrst_gpio_oe", {16'h0, gpio_oe}, 32'h00000000);
        modelReset();
        got_q.delete();
        applyStimulus(1'b1, 1'b1, 5);
        rst_n = 1'b1;
        repeat (10) @(negedge s_clk_25mhz);
        wbuf[0] = 8'hC3;
        i2cWriteRegs(3'd3, 1, "postrst");
        checkStrobes("postrst");
        checkModel("postrst");
        i2cReadRegs(3'd3, 2, "postrst_rd");
        i2cStop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_gpio_target.md
Name: i2c_gpio_target

Overview:
- I2C target (slave) that models a 16-bit I2C GPIO expander with a 0x02/0x03 output and 0x06/0x07 config register map.
- Sits at the far end of the gate-GPIO I2C bus, both as an on-chip loopback responder for self-test and as the bench model for the existing I2C master.
- Decodes write and read transactions from SCL/SDA, holds output/polarity/config registers and drives the resulting gpio outputs.
- Runs in the system clock domain; SCL and SDA are oversampled.

Parameters:
- ADDR7, 7'h74, 7-bit target address (8'hE8 write / 8'hE9 read on the wire).
- SYNC_STAGES, 2, synchroniser depth for scl_in/sda_in; legal values 2..3.

Ports:
- s_clk_25mhz  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  bus SCL, asynchronous.
- sda_in  input  1  bus SDA, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release. Top level forms the open-drain pad.
- gpio_in  input  16  pin levels read back through registers 0/1.
- gpio_out  output  16  {reg3, reg2}.
- gpio_oe  output  16  ~{reg7, reg6}; config bit 0 = output.
- wr_strobe  output  1  one-clock pulse when a data byte is committed.
- wr_reg  output  3  register index of the last commit; valid with wr_strobe.

Behaviour:
- Reset values: sda_oe=0, wr_strobe=0, wr_reg=0, reg2=reg3=8'hFF, reg4=reg5=8'h00, reg6=reg7=8'hFF, giving gpio_out=16'hFFFF and gpio_oe=16'h0000. Pointer=0, state=IDLE.
- Input sampling: scl_in and sda_in pass through SYNC_STAGES flops, then one history flop for edge detection.
- Bus events (all on synchronised signals):
  - START: scl high and sda falling.
  - STOP: scl high and sda rising.
  - Data is sampled on the SCL rising edge; SDA is changed only on a detected SCL falling edge.
- Timing requirement: SCL high and low phases must each be ≥ 4 clocks (1.25 MHz SCL gives 10).
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state → ADDR, bit count cleared. Repeated START is allowed; the pointer is kept.
- STOP from any state → IDLE with sda_oe=0 on the next clock.
- ADDR: shift 8 bits MSB first.
  - Address[7:1]==ADDR7 → ADDR_ACK. Otherwise → IGNORE (no ACK; wait for START/STOP).
  - R/W bit is latched.
- Any *_ACK state where the target drives ACK:
  - sda_oe=1 from the SCL falling edge after bit 8 until the next SCL falling edge.
  - Then release, or drive the first read bit.
- After ADDR_ACK: W → PTR; R → RDATA.
- PTR byte:
  - Value ≤ 8'h07 → ACK, pointer=value[2:0], → WDATA.
  - Value > 8'h07 → NACK, pointer unchanged, → IGNORE.
- WDATA, on bit 8:
  - Pointer 2..7 → register written.
  - Pointer 0/1 → write discarded; the byte is still ACKed.
  - wr_strobe pulses and wr_reg=pointer in the same clock, only for pointer 2..7.
  - Then pointer[0] toggles (pair wrap, e.g. 3→2, 7→6) and → WDATA for the next byte.
- RDATA:
  - Byte loaded at the SCL falling edge ending the ACK.
  - Registers 0/1 return gpio_in[7:0]/[15:8] XOR reg4/reg5, captured at load time. Other registers return their stored value.
  - Each bit is driven as sda_oe = ~bit.
  - After bit 8, SDA is released. The master's ACK bit is sampled on SCL rise.
  - Master ACK → pointer[0] toggles → RDATA. Master NACK → IGNORE.
- Register updates take effect on gpio_out/gpio_oe the clock after commit. No partial update on mid-byte START/STOP.
- Reset mid-transfer: immediate release of SDA and restore of reset values.

Decomposition:
- Package i2c_gpio_pkg holds:
  - State enum.
  - Register indices REG_IN0..REG_CFG1 (0..7).
  - Reset constants OUT_RST=8'hFF, POL_RST=8'h00, CFG_RST=8'hFF.
- One natural sub-module: i2c_bus_sync. It contains the synchronisers and edge detection, and outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write E8,06,00 then E8,07,00 → all three bytes ACKed; gpio_oe=16'hFFFF; wr_reg pulses 6 then 7.
- Write E8,02,5A,A5 → reg2=5A, reg3=A5 (pair toggle); gpio_out=16'hA55A; two wr_strobe pulses.
- Write E8,00, repeated START, E9, read 2 bytes (ACK then NACK) with gpio_in=16'h1234 and reg4=FF → returns CB then 12; SDA released after NACK.
- Address E0 → no ACK (SDA high in 9th clock); registers unchanged; later E8 transaction works.
- Pointer 8'h09 → NACK, subsequent data ignored; STOP mid-byte inside WDATA → no register change, sda_oe=0.
- Assert rst_n low while the target holds an ACK → sda_oe=0 asynchronously; gpio_out=16'hFFFF, gpio_oe=0.
